// File: rtl/serial_logic_unit.sv
// Iterative bitwise logic unit: evaluates AND/OR/NOR/XOR on CHUNK bits per cycle,
// low chunk first, behind valid/ready request and response handshakes.
module serial_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [1:0]       inOp,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outC,
    output logic             outZero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [CHUNK-1:0] chunk_op(
        input logic [1:0]       op,
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b
    );
        logic [CHUNK-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = ~(a | b);
            2'b11:   r = a ^ b;
            default: r = {CHUNK{1'b0}};
        endcase
        return r;
    endfunction

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] out_c_q;
    logic             out_zero_q;

    // Working result with the chunk selected by the counter replaced by its new value.
    always_comb begin
        res_d = res_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == k[CW-1:0]) begin
                res_d[k*CHUNK +: CHUNK] = chunk_op(op_q, a_q[k*CHUNK +: CHUNK], b_q[k*CHUNK +: CHUNK]);
            end else begin
                res_d[k*CHUNK +: CHUNK] = res_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // Control FSM and datapath registers; outC/outZero load only on the final chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            op_q       <= 2'b00;
            res_q      <= {WIDTH{1'b0}};
            out_c_q    <= {WIDTH{1'b0}};
            out_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inValid) begin
                        a_q     <= inA;
                        b_q     <= inB;
                        op_q    <= inOp;
                        cnt_q   <= {CW{1'b0}};
                        res_q   <= {WIDTH{1'b0}};
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CHUNK) begin
                        out_c_q    <= res_d;
                        out_zero_q <= (res_d == {WIDTH{1'b0}});
                        cnt_q      <= {CW{1'b0}};
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign outC     = out_c_q;
    assign outZero  = out_zero_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: vector table plus hand-written
// backpressure, busy-ignore, mid-flight reset and back-to-back sequences.
module tb_serial_logic_unit;

    localparam int NCHUNK = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [1:0]  inOp;
    logic        outValid;
    logic        outReady;
    logic [31:0] outC;
    logic        outZero;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_logic_unit #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .inA(inA), .inB(inB), .inOp(inOp),
        .outValid(outValid), .outReady(outReady), .outC(outC), .outZero(outZero)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        z;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for inReady, present one request and return the cycle stamp after the accept edge.
    task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, output int acc);
        int n = 0;
        while (!inReady && n < 40) begin tick(); n++; end
        chk("req_ready", {31'd0, inReady}, 32'd1);
        inValid = 1'b1; inA = a; inB = b; inOp = op; outReady = rdy;
        tick();
        acc = cyc;
        inValid = 1'b0;
    endtask

    // Edges from the accept edge until outValid is seen; 40 means timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!outValid && lat < 40) begin tick(); lat++; end
    endtask

    initial begin
        int acc;
        int lat;
        int seen;
        int accs[3];
        logic [1:0]  bop[3];
        logic [31:0] ba[3];
        logic [31:0] bb[3];
        logic [31:0] bc[3];

        vecs[0] = '{2'b10, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 1'b0};
        vecs[1] = '{2'b00, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1};
        vecs[2] = '{2'b01, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1};
        vecs[4] = '{2'b00, 32'h8000_0001, 32'hFFFF_FFFF, 32'h80000001, 1'b0};
        vecs[5] = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000000F, 1'b0};

        bop[0] = 2'b00; ba[0] = 32'hFFFF0000; bb[0] = 32'h0F0F0F0F; bc[0] = 32'h0F0F0000;
        bop[1] = 2'b01; ba[1] = 32'h00000011; bb[1] = 32'h00000100; bc[1] = 32'h00000111;
        bop[2] = 2'b11; ba[2] = 32'hAAAAAAAA; bb[2] = 32'h55555555; bc[2] = 32'hFFFFFFFF;

        rst_n = 1'b0; inValid = 1'b0; inA = 32'd0; inB = 32'd0; inOp = 2'b00; outReady = 1'b0;
        tick(); tick();
        chk("rst_inReady", {31'd0, inReady}, 32'd1);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_outC", outC, 32'd0);
        chk("rst_outZero", {31'd0, outZero}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            req(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, acc);
            wait_done(lat);
            chk("latency", lat, NCHUNK);
            chk("vec_outValid", {31'd0, outValid}, 32'd1);
            chk("vec_outC", outC, vecs[i].c);
            chk("vec_outZero", {31'd0, outZero}, {31'd0, vecs[i].z});
            tick();
            chk("vec_after_outValid", {31'd0, outValid}, 32'd0);
            chk("vec_after_inReady", {31'd0, inReady}, 32'd1);
        end

        // Backpressure: result must hold while the consumer stalls.
        req(2'b11, 32'h12345678, 32'hFFFFFFFF, 1'b0, acc);
        wait_done(lat);
        chk("bp_latency", lat, NCHUNK);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("bp_outValid", {31'd0, outValid}, 32'd1);
            chk("bp_outC", outC, 32'hEDCBA987);
            chk("bp_outZero", {31'd0, outZero}, 32'd0);
        end
        outReady = 1'b1;
        tick();
        chk("bp_release_outValid", {31'd0, outValid}, 32'd0);
        chk("bp_release_inReady", {31'd0, inReady}, 32'd1);

        // Input activity during BUSY must be ignored.
        req(2'b01, 32'h00000001, 32'h00000002, 1'b1, acc);
        for (int j = 0; j < 4; j++) begin
            inValid = ~inValid;
            inA = 32'hFFFFFFFF;
            tick();
            chk("busy_inReady", {31'd0, inReady}, 32'd0);
        end
        inValid = 1'b0;
        wait_done(lat);
        chk("busy_outC", outC, 32'h00000003);
        tick();

        // Reset at BUSY chunk 3 discards the in-flight result.
        req(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, acc);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_outValid", {31'd0, outValid}, 32'd0);
        chk("mid_rst_inReady", {31'd0, inReady}, 32'd1);
        chk("mid_rst_outC", outC, 32'd0);
        chk("mid_rst_outZero", {31'd0, outZero}, 32'd0);
        seen = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (outValid) seen++;
        end
        chk("mid_rst_no_response", seen, 0);
        req(2'b10, 32'd0, 32'd0, 1'b1, acc);
        wait_done(lat);
        chk("post_rst_outC", outC, 32'hFFFFFFFF);
        chk("post_rst_outZero", {31'd0, outZero}, 32'd0);
        tick();

        // Back-to-back with inValid and outReady held high.
        outReady = 1'b1;
        inValid = 1'b1; inOp = bop[0]; inA = ba[0]; inB = bb[0];
        for (int i = 0; i < 3; i++) begin
            seen = 0;
            while (!inReady && seen < 40) begin tick(); seen++; end
            chk("b2b_ready", {31'd0, inReady}, 32'd1);
            accs[i] = cyc + 1;
            tick();
            if (i < 2) begin
                inOp = bop[i+1]; inA = ba[i+1]; inB = bb[i+1];
            end else begin
                inValid = 1'b0;
            end
            wait_done(lat);
            chk("b2b_outC", outC, bc[i]);
            if (i > 0) chk("b2b_spacing", accs[i] - accs[i-1], NCHUNK + 2);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
